// File: rtl/cosim_msg_serializer_pkg.sv
// Shared types and sizing helpers for the cosim message serializer.
package cosim_msg_serializer_pkg;

  localparam int MSG_BITS_DEFAULT  = 1026;
  localparam int WORD_BITS_DEFAULT = 64;

  typedef enum logic {IDLE, SEND} state_e;

  function automatic int num_words(input int msg_bits, input int word_bits);
    return (msg_bits + word_bits - 1) / word_bits;
  endfunction

  // A single-word message still needs a 1-bit index port.
  function automatic int idx_bits(input int nwords);
    return (nwords <= 1) ? 1 : $clog2(nwords);
  endfunction

endpackage

// File: rtl/cosim_msg_serializer_if.sv
// Wide message in / narrow word stream out, as seen between endpoint, serializer and sink.
interface cosim_msg_serializer_if
  import cosim_msg_serializer_pkg::*;
#(
  parameter int MSG_BITS  = MSG_BITS_DEFAULT,
  parameter int WORD_BITS = WORD_BITS_DEFAULT
);
  localparam int IDX_BITS = idx_bits(num_words(MSG_BITS, WORD_BITS));

  logic [MSG_BITS-1:0]  DataIn;
  logic                 DataInValid;
  logic                 DataInReady;
  logic [WORD_BITS-1:0] DataOut;
  logic                 DataOutValid;
  logic                 DataOutReady;
  logic                 DataOutLast;
  logic [IDX_BITS-1:0]  DataOutIdx;

  // master: endpoint plus downstream sink; slave: the serializer
  modport master (
    output DataIn, DataInValid, DataOutReady,
    input  DataInReady, DataOut, DataOutValid, DataOutLast, DataOutIdx
  );
  modport slave (
    input  DataIn, DataInValid, DataOutReady,
    output DataInReady, DataOut, DataOutValid, DataOutLast, DataOutIdx
  );
endinterface

// File: rtl/cosim_msg_serializer.sv
// Splits one wide cosim DataOut message into LSB-first narrow words with idx/last tags.
module cosim_msg_serializer
  import cosim_msg_serializer_pkg::*;
#(
  parameter int MSG_BITS  = MSG_BITS_DEFAULT,
  parameter int WORD_BITS = WORD_BITS_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  cosim_msg_serializer_if.slave     bus,
  output logic [31:0]               MsgCount
);
  localparam int NUM_WORDS = num_words(MSG_BITS, WORD_BITS);
  localparam int IDX_BITS  = idx_bits(NUM_WORDS);
  localparam int BUF_BITS  = NUM_WORDS * WORD_BITS;

  state_e                                state, nstate;
  logic [IDX_BITS-1:0]                   idx;
  logic [NUM_WORDS-1:0][WORD_BITS-1:0]   buffer;
  logic                                  last, out_fire, in_fire;

  assign last     = (idx == IDX_BITS'(NUM_WORDS - 1));
  assign out_fire = (state == SEND) && bus.DataOutReady;
  assign in_fire  = bus.DataInValid && bus.DataInReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // A new capture always lands in SEND, including the last-word overlap.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (in_fire) nstate = SEND;
      SEND:    if (out_fire && last) nstate = in_fire ? SEND : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    bus.DataInReady  = 1'b0;
    bus.DataOutValid = 1'b0;
    if (!rst) begin
      bus.DataInReady  = (state == IDLE) || (out_fire && last);
      bus.DataOutValid = (state == SEND);
    end
  end

  assign bus.DataOut     = buffer[idx];
  assign bus.DataOutIdx  = idx;
  assign bus.DataOutLast = last;

  // Upper pad bits of the final word come from the zero-extension on capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer   <= '0;
      idx      <= '0;
      MsgCount <= '0;
    end else begin
      if (in_fire) begin
        buffer <= BUF_BITS'(bus.DataIn);
        idx    <= '0;
      end else if (out_fire && !last) begin
        idx <= idx + 1'b1;
      end
      if (out_fire && last) MsgCount <= MsgCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_cosim_msg_serializer.sv
// Randomized bench for cosim_msg_serializer against a word-queue reference model.
module tb_cosim_msg_serializer;
  localparam int MB = 1026;
  localparam int WB = 64;
  localparam int NW = 17;

  typedef struct {
    logic [63:0] d;
    int          idx;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] cnt, s_cnt;

  cosim_msg_serializer_if #(.MSG_BITS(MB), .WORD_BITS(WB)) bi();
  cosim_msg_serializer_if #(.MSG_BITS(64), .WORD_BITS(64)) si();

  cosim_msg_serializer #(.MSG_BITS(MB), .WORD_BITS(WB)) dut (
    .clk(clk), .rst(rst), .bus(bi.slave), .MsgCount(cnt)
  );
  cosim_msg_serializer #(.MSG_BITS(64), .WORD_BITS(64)) dut_s (
    .clk(clk), .rst(rst), .bus(si.slave), .MsgCount(s_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  word_t q[$];
  logic [31:0] m_cnt = '0;
  int beats = 0;
  int cycs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [MB-1:0] rand_msg();
    logic [MB-1:0] m = '0;
    for (int i = 0; i < (MB + 31) / 32; i++) m = (m << 32) | MB'($urandom);
    return m;
  endfunction

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic cycle(input logic iv, input logic [MB-1:0] msg, input logic ordy,
                       output logic acc);
    logic [MB-1:0] tmp;
    logic          exp_rdy;
    word_t         w;
    @(negedge clk);
    bi.DataInValid  = iv;
    bi.DataIn       = msg;
    bi.DataOutReady = ordy;
    #1;
    cycs++;
    exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
    chk("msgcount", 64'(cnt), 64'(m_cnt));
    chk("out_valid", 64'(bi.DataOutValid), 64'(q.size() > 0));
    chk("in_ready", 64'(bi.DataInReady), 64'(exp_rdy));
    if (q.size() > 0) begin
      chk("data", bi.DataOut, q[0].d);
      chk("idx", 64'(bi.DataOutIdx), 64'(q[0].idx));
      chk("last", 64'(bi.DataOutLast), 64'(q[0].last));
      if (ordy) begin
        if (q[0].last) m_cnt = m_cnt + 32'd1;
        void'(q.pop_front());
        beats++;
      end
    end
    acc = iv && exp_rdy;
    if (acc) begin
      for (int k = 0; k < NW; k++) begin
        tmp    = msg >> (k * WB);
        w.d    = tmp[63:0];
        w.idx  = k;
        w.last = (k == NW - 1);
        q.push_back(w);
      end
    end
  endtask

  // mode 0: ready always; 1: random ready; 2: ready pattern 1,0,0,1
  function automatic logic rdy_of(input int mode, input int step);
    case (mode)
      0:       return 1'b1;
      1:       return $urandom_range(0, 3) != 0;
      default: return (step % 4 == 0) || (step % 4 == 3);
    endcase
  endfunction

  task automatic send(input logic [MB-1:0] msg, input int mode);
    logic acc = 1'b0;
    int   n = 0;
    while (!acc && n < 200) begin
      cycle(1'b1, msg, rdy_of(mode, n), acc);
      n++;
    end
    if (!acc) chk("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain(input int mode);
    logic acc;
    int   n = 0;
    while (q.size() > 0 && n < 400) begin
      cycle(1'b0, '0, rdy_of(mode, n), acc);
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [MB-1:0] m;
    logic          acc;
    int            b0, c0;
    logic [63:0]   prev;
    bi.DataIn = '0; bi.DataInValid = 1'b0; bi.DataOutReady = 1'b0;
    si.DataIn = '0; si.DataInValid = 1'b0; si.DataOutReady = 1'b0;

    // reset state while rst is held
    #3;
    chk("rst_in_ready", 64'(bi.DataInReady), 64'd0);
    chk("rst_out_valid", 64'(bi.DataOutValid), 64'd0);
    chk("rst_msgcount", 64'(cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, '0, 1'b0, acc);

    // directed message: low word pattern plus the two top bits
    m = '0;
    m[63:0]      = 64'h0123_4567_89AB_CDEF;
    m[1025:1024] = 2'b11;
    b0 = beats;
    send(m, 0);
    drain(0);
    cycle(1'b0, '0, 1'b1, acc);
    chk("dir_beats", 64'(beats - b0), 64'(NW));
    chk("dir_count", 64'(cnt), 64'd1);

    // backpressure 1,0,0,1
    b0 = beats;
    send(rand_msg(), 0);
    drain(2);
    chk("bp_beats", 64'(beats - b0), 64'(NW));

    // back-to-back with DataInValid held and full ready
    send(rand_msg(), 0);
    b0 = beats; c0 = cycs;
    send(rand_msg(), 0);
    drain(0);
    chk("b2b_beats", 64'(beats - b0), 64'(2 * NW));
    chk("b2b_cycles", 64'(cycs - c0), 64'(2 * NW));
    cycle(1'b0, '0, 1'b1, acc);

    // random traffic with random backpressure and gaps
    for (int i = 0; i < 20; i++) begin
      send(rand_msg(), 1);
      if ($urandom_range(0, 2) == 0) cycle(1'b0, '0, 1'b1, acc);
    end
    drain(1);
    cycle(1'b0, '0, 1'b1, acc);

    // reset pulse mid-message at idx 7
    send(rand_msg(), 0);
    while (q.size() > 0 && q[0].idx < 7) cycle(1'b0, '0, 1'b1, acc);
    chk("pre_rst_idx", 64'(q[0].idx), 64'd7);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bi.DataOutValid), 64'd0);
    chk("midrst_in_ready", 64'(bi.DataInReady), 64'd0);
    chk("midrst_count", 64'(cnt), 64'd0);
    q.delete();
    m_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    send(rand_msg(), 1);
    drain(1);
    cycle(1'b0, '0, 1'b1, acc);
    chk("post_rst_count", 64'(cnt), 64'd1);

    // MsgCount wrap
    force dut.MsgCount = 32'hFFFF_FFFF;
    #1;
    release dut.MsgCount;
    m_cnt = 32'hFFFF_FFFF;
    send(rand_msg(), 0);
    drain(0);
    cycle(1'b0, '0, 1'b1, acc);
    chk("wrap_count", 64'(cnt), 64'd0);

    // single-word instance: one message per cycle, every word last at idx 0
    prev = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      si.DataIn       = {$urandom, $urandom};
      si.DataInValid  = 1'b1;
      si.DataOutReady = 1'b1;
      #1;
      chk("s_in_ready", 64'(si.DataInReady), 64'd1);
      chk("s_out_valid", 64'(si.DataOutValid), 64'(i > 0));
      chk("s_count", 64'(s_cnt), 64'(i > 0 ? i - 1 : 0));
      if (i > 0) begin
        chk("s_data", si.DataOut, prev);
        chk("s_last", 64'(si.DataOutLast), 64'd1);
        chk("s_idx", 64'(si.DataOutIdx), 64'd0);
      end
      prev = si.DataIn;
    end
    @(negedge clk);
    si.DataInValid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
